// File: rtl/pwrmgr_pkg.sv
// Shared power-manager types and constants used by the slow-domain wakeup arbiter.
package pwrmgr_pkg;

    typedef enum logic [1:0] {
        WaIdle    = 2'd0,
        WaArmed   = 2'd1,
        WaReqWake = 2'd2,
        WaReqRst  = 2'd3
    } wake_arb_state_e;

    // Widest filter counter any instance can need (FilterCycles tops out at 15).
    localparam int unsigned WakeFilterCyclesMax = 15;
    localparam int unsigned WakeFilterW         = $clog2(WakeFilterCyclesMax + 1);

endpackage

// File: rtl/pwrmgr_wake_filter.sv
// Single-source wakeup glitch filter: saturating run-length counter plus qualify output.
module pwrmgr_wake_filter
    import pwrmgr_pkg::*;
#(
    parameter int unsigned FilterCycles = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic cnt_en_i,
    input  logic filt_en_i,
    input  logic req_i,
    output logic qual_o
);

    localparam int unsigned CntW = $clog2(FilterCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (cnt_en_i) begin
            if (!req_i) begin
                cnt_q <= '0;
            end else if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    // Qualify on the sample that brings the run to FilterCycles, not the one after.
    always_comb begin
        qual_o = req_i & (~filt_en_i | (cnt_q == CntMax) |
                          (cnt_en_i & (cnt_q == CntMax - CntW'(1))));
    end

endmodule

// File: rtl/pwrmgr_wake_arb.sv
// Slow-domain wakeup/reset request arbiter: qualifies, prioritises and latches requests
// for the slow FSM, holding them until the power-up cause toggles.
module pwrmgr_wake_arb
    import pwrmgr_pkg::*;
#(
    parameter int unsigned NumWkups     = 4,
    parameter int unsigned NumRstReqs   = 2,
    parameter int unsigned FilterCycles = 3,
    localparam int unsigned WkupIdxW    = (NumWkups > 1) ? $clog2(NumWkups) : 1,
    localparam int unsigned RstIdxW     = (NumRstReqs > 1) ? $clog2(NumRstReqs) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumWkups-1:0]   wakeup_req_i,
    input  logic [NumWkups-1:0]   wakeup_en_i,
    input  logic [NumWkups-1:0]   wakeup_filt_en_i,
    input  logic [NumRstReqs-1:0] rst_req_i,
    input  logic [NumRstReqs-1:0] rst_en_i,
    input  logic                  lp_entry_i,
    input  logic                  pwrup_cause_toggle_i,
    input  logic                  clr_info_i,
    output logic                  wakeup_o,
    output logic                  reset_req_o,
    output logic [NumWkups-1:0]   wake_info_o,
    output logic [WkupIdxW-1:0]   wake_src_o,
    output logic [RstIdxW-1:0]    rst_src_o,
    output logic                  src_valid_o,
    output wake_arb_state_e       state_o
);

    // Handshake: a request is raised by entering WaReqWake/WaReqRst and is considered
    // accepted on any level change of pwrup_cause_toggle_i while held; no valid/ready pair.

    wake_arb_state_e       state_q, state_d;
    logic                  toggle_q;
    logic                  toggle_edge;
    logic [NumWkups-1:0]   eff;
    logic [NumWkups-1:0]   qual;
    logic [NumRstReqs-1:0] rq;
    logic [WkupIdxW-1:0]   wake_idx;
    logic [RstIdxW-1:0]    rst_idx;
    logic                  cap_rst, cap_wake, info_or;
    logic                  wakeup_d, reset_req_d;

    assign eff         = wakeup_req_i & wakeup_en_i;
    assign rq          = rst_req_i & rst_en_i;
    assign toggle_edge = pwrup_cause_toggle_i ^ toggle_q;

    for (genvar i = 0; i < NumWkups; i++) begin : g_filt
        pwrmgr_wake_filter #(
            .FilterCycles(FilterCycles)
        ) u_filt (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clr_i    (state_q == WaIdle),
            .cnt_en_i (state_q == WaArmed),
            .filt_en_i(wakeup_filt_en_i[i]),
            .req_i    (eff[i]),
            .qual_o   (qual[i])
        );
    end

    // Lowest index wins within each group.
    always_comb begin
        wake_idx = '0;
        for (int i = NumWkups - 1; i >= 0; i--) begin
            if (qual[i]) wake_idx = WkupIdxW'(i);
        end
        rst_idx = '0;
        for (int j = NumRstReqs - 1; j >= 0; j--) begin
            if (rq[j]) rst_idx = RstIdxW'(j);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= WaIdle;
            toggle_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            toggle_q <= pwrup_cause_toggle_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WaIdle:    if (lp_entry_i) state_d = WaArmed;
            WaArmed: begin
                if (|rq)        state_d = WaReqRst;
                else if (|qual) state_d = WaReqWake;
            end
            WaReqWake: if (toggle_edge) state_d = WaIdle;
            WaReqRst:  if (toggle_edge) state_d = WaIdle;
            default:   state_d = WaIdle;
        endcase
    end

    always_comb begin
        cap_rst     = (state_q == WaArmed) & (|rq);
        cap_wake    = (state_q == WaArmed) & ~(|rq) & (|qual);
        info_or     = cap_wake | (state_q == WaReqWake);
        wakeup_d    = (state_d == WaReqWake);
        reset_req_d = (state_d == WaReqRst);
    end

    // A clear coinciding with new qualified bits drops the old record but keeps the new bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wakeup_o    <= 1'b0;
            reset_req_o <= 1'b0;
            wake_info_o <= '0;
            wake_src_o  <= '0;
            rst_src_o   <= '0;
            src_valid_o <= 1'b0;
        end else begin
            wakeup_o    <= wakeup_d;
            reset_req_o <= reset_req_d;
            if (info_or) begin
                wake_info_o <= (clr_info_i ? '0 : wake_info_o) | qual;
            end else if (clr_info_i) begin
                wake_info_o <= '0;
            end
            if (cap_rst) rst_src_o <= rst_idx;
            if (cap_wake) wake_src_o <= wake_idx;
            if (cap_rst || cap_wake) begin
                src_valid_o <= 1'b1;
            end else if (clr_info_i) begin
                src_valid_o <= 1'b0;
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_pwrmgr_wake_arb.sv
// Directed self-checking bench for pwrmgr_wake_arb with hand-computed expectations.
module tb_pwrmgr_wake_arb;
    import pwrmgr_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [3:0]      wakeup_req_i = '0;
    logic [3:0]      wakeup_en_i = '0;
    logic [3:0]      wakeup_filt_en_i = '0;
    logic [1:0]      rst_req_i = '0;
    logic [1:0]      rst_en_i = '0;
    logic            lp_entry_i = 1'b0;
    logic            pwrup_cause_toggle_i = 1'b0;
    logic            clr_info_i = 1'b0;
    logic            wakeup_o;
    logic            reset_req_o;
    logic [3:0]      wake_info_o;
    logic [1:0]      wake_src_o;
    logic            rst_src_o;
    logic            src_valid_o;
    wake_arb_state_e state_o;

    int n_checks = 0;
    int n_pass   = 0;

    pwrmgr_wake_arb #(
        .NumWkups(4), .NumRstReqs(2), .FilterCycles(3)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .wakeup_req_i        (wakeup_req_i),
        .wakeup_en_i         (wakeup_en_i),
        .wakeup_filt_en_i    (wakeup_filt_en_i),
        .rst_req_i           (rst_req_i),
        .rst_en_i            (rst_en_i),
        .lp_entry_i          (lp_entry_i),
        .pwrup_cause_toggle_i(pwrup_cause_toggle_i),
        .clr_info_i          (clr_info_i),
        .wakeup_o            (wakeup_o),
        .reset_req_o         (reset_req_o),
        .wake_info_o         (wake_info_o),
        .wake_src_o          (wake_src_o),
        .rst_src_o           (rst_src_o),
        .src_valid_o         (src_valid_o),
        .state_o             (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic lp_entry();
        lp_entry_i = 1'b1;
        tick();
        lp_entry_i = 1'b0;
    endtask

    task automatic flip_toggle();
        pwrup_cause_toggle_i = ~pwrup_cause_toggle_i;
        tick();
    endtask

    initial begin
        // Reset
        #12;
        check("rst_wakeup", 32'(wakeup_o), 32'd0);
        check("rst_reset_req", 32'(reset_req_o), 32'd0);
        check("rst_info", 32'(wake_info_o), 32'd0);
        check("rst_valid", 32'(src_valid_o), 32'd0);
        check("rst_state", 32'(state_o), 32'(WaIdle));
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Filtered source 2 held for three samples
        wakeup_en_i = 4'b0100;
        wakeup_filt_en_i = 4'b0100;
        lp_entry();
        check("armed_state", 32'(state_o), 32'(WaArmed));
        wakeup_req_i = 4'b0100;
        tick();
        check("filt_s1", 32'(wakeup_o), 32'd0);
        tick();
        check("filt_s2", 32'(wakeup_o), 32'd0);
        tick();
        check("filt_wake", 32'(wakeup_o), 32'd1);
        check("filt_src", 32'(wake_src_o), 32'd2);
        check("filt_info", 32'(wake_info_o), 32'h4);
        check("filt_valid", 32'(src_valid_o), 32'd1);

        // Toggle handshake, then a stray toggle in idle
        flip_toggle();
        check("ack_wakeup", 32'(wakeup_o), 32'd0);
        check("ack_state", 32'(state_o), 32'(WaIdle));
        wakeup_req_i = '0;
        flip_toggle();
        check("idle_toggle_wakeup", 32'(wakeup_o), 32'd0);
        check("idle_toggle_state", 32'(state_o), 32'(WaIdle));

        // Two-cycle glitch must not qualify
        lp_entry();
        wakeup_req_i = 4'b0100;
        tick();
        tick();
        wakeup_req_i = '0;
        tick();
        check("glitch_wakeup", 32'(wakeup_o), 32'd0);
        tick();
        check("glitch_state", 32'(state_o), 32'(WaArmed));

        // Clear alone while armed
        clr_info_i = 1'b1;
        tick();
        clr_info_i = 1'b0;
        check("clr_info", 32'(wake_info_o), 32'd0);
        check("clr_valid", 32'(src_valid_o), 32'd0);

        // Reset request beats a same-cycle wakeup
        wakeup_en_i = 4'b0010;
        wakeup_filt_en_i = 4'b0000;
        wakeup_req_i = 4'b0010;
        rst_en_i = 2'b01;
        rst_req_i = 2'b01;
        tick();
        check("prio_reset_req", 32'(reset_req_o), 32'd1);
        check("prio_rst_src", 32'(rst_src_o), 32'd0);
        check("prio_wakeup", 32'(wakeup_o), 32'd0);
        check("prio_info", 32'(wake_info_o), 32'd0);
        check("prio_valid", 32'(src_valid_o), 32'd1);
        tick();
        check("prio_hold", 32'(reset_req_o), 32'd1);
        flip_toggle();
        check("rst_ack", 32'(reset_req_o), 32'd0);
        check("rst_ack_state", 32'(state_o), 32'(WaIdle));
        wakeup_req_i = '0;
        rst_req_i = '0;

        // Only enabled source 3 counts; late reset request not promoted
        lp_entry();
        wakeup_en_i = 4'b1000;
        wakeup_req_i = 4'b1111;
        tick();
        check("en_wakeup", 32'(wakeup_o), 32'd1);
        check("en_src", 32'(wake_src_o), 32'd3);
        check("en_info", 32'(wake_info_o), 32'h8);
        rst_en_i = 2'b10;
        rst_req_i = 2'b10;
        tick();
        check("late_rst_req", 32'(reset_req_o), 32'd0);
        check("late_rst_state", 32'(state_o), 32'(WaReqWake));
        rst_req_i = '0;
        flip_toggle();
        check("en_ack", 32'(wakeup_o), 32'd0);

        // Clear coinciding with capture: capture wins
        lp_entry();
        wakeup_en_i = 4'b0001;
        wakeup_req_i = 4'b0001;
        clr_info_i = 1'b1;
        tick();
        clr_info_i = 1'b0;
        check("race_info", 32'(wake_info_o), 32'h1);
        check("race_src", 32'(wake_src_o), 32'd0);
        check("race_valid", 32'(src_valid_o), 32'd1);
        wakeup_req_i = '0;
        tick();
        clr_info_i = 1'b1;
        tick();
        clr_info_i = 1'b0;
        check("late_clr_info", 32'(wake_info_o), 32'd0);
        check("late_clr_valid", 32'(src_valid_o), 32'd0);
        check("late_clr_wakeup", 32'(wakeup_o), 32'd1);

        // Asynchronous reset mid-request
        rst_ni = 1'b0;
        #1;
        check("async_wakeup", 32'(wakeup_o), 32'd0);
        check("async_state", 32'(state_o), 32'(WaIdle));
        @(negedge clk_i);
        rst_ni = 1'b1;
        wakeup_req_i = 4'b0001;
        tick();
        tick();
        check("post_rst_idle", 32'(wakeup_o), 32'd0);
        lp_entry();
        tick();
        check("post_rst_wake", 32'(wakeup_o), 32'd1);
        check("post_rst_src", 32'(wake_src_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwrmgr_wake_arb.md
Name: pwrmgr_wake_arb

Overview:
Slow-clock-domain front end that collects per-peripheral wakeup and reset requests, filters and qualifies them, and latches them. It arbitrates them into the single wakeup_o / reset_req_o pair consumed by the power manager slow FSM, and records which source won. It holds the request until the slow FSM acknowledges it via a toggle of the power-up cause, then re-arms for the next low-power cycle.

Parameters:
NumWkups, 4, number of wakeup sources (1..16)
NumRstReqs, 2, number of peripheral reset-request sources (1..8)
FilterCycles, 3, consecutive high samples needed before a filtered wakeup counts (1..15)

Ports:
clk_i  in  1  slow (always-on) clock
rst_ni  in  1  asynchronous reset, active-low
wakeup_req_i  in  NumWkups  synchronized wakeup requests, level
wakeup_en_i  in  NumWkups  per-source wakeup enable (static while armed)
wakeup_filt_en_i  in  NumWkups  per-source filter enable
rst_req_i  in  NumRstReqs  synchronized reset requests, level
rst_en_i  in  NumRstReqs  per-source reset enable
lp_entry_i  in  1  pulse: low-power entry committed (fast side ack_pwrdn complete)
pwrup_cause_toggle_i  in  1  cause toggle from slow FSM
clr_info_i  in  1  pulse: clear captured wake info
wakeup_o  out  1  registered wakeup to slow FSM
reset_req_o  out  1  registered reset request to slow FSM
wake_info_o  out  NumWkups  sticky record of qualified wakeups
wake_src_o  out  $clog2(NumWkups)  index of winning wakeup source
rst_src_o  out  $clog2(NumRstReqs)  index of winning reset source
src_valid_o  out  1  wake_src_o / rst_src_o valid

Behaviour:
- Reset values: all outputs 0; state WaIdle; filter counters 0; toggle sample 0.
- Qualification per wakeup source i: eff_i = wakeup_req_i[i] & wakeup_en_i[i]. If filt_en, a saturating counter increments while eff_i=1 and clears on eff_i=0. The source is qualified when the count reaches FilterCycles, first on the FilterCycles-th consecutive high sample. Unfiltered sources qualify in the cycle eff_i=1. Counters run only in WaArmed.
- Reset qualification: rq_j = rst_req_i[j] & rst_en_i[j]. No filter.
- Priority: reset over wakeup. Lowest index wins within each group.
- FSM states:
  - WaIdle: outputs held low. lp_entry_i -> WaArmed.
  - WaArmed: any rq_j -> WaReqRst (capture rst_src, src_valid=1). Else any qualified wakeup -> WaReqWake (capture wake_src, src_valid=1; OR all qualified bits into wake_info).
  - WaReqRst: reset_req_o=1. Edge on pwrup_cause_toggle_i -> WaIdle, with reset_req_o=0 on the next cycle.
  - WaReqWake: wakeup_o=1. Additional qualified wakeups keep OR-ing into wake_info. A rq_j arriving here is not promoted and is sampled after the next lp_entry. Toggle edge -> WaIdle, wakeup_o drops.
  - Illegal state encoding -> WaIdle with all outputs 0.
- Latency: qualified event at cycle N -> state change at N+1 -> wakeup_o/reset_req_o high at N+1 (registered from state_d).
- Toggle edge detect: toggle_q samples pwrup_cause_toggle_i every cycle. Edge = input != toggle_q. Edges in WaIdle/WaArmed are ignored.
- Simultaneous events:
  - lp_entry_i in a non-Idle state is ignored.
  - clr_info_i together with a new capture: the capture wins.
  - clr_info_i clears wake_info_o and src_valid_o only; sources stay 0 until the next capture.
- Filter counters reset to 0 on every entry to WaArmed.
- Width rule: counters are $clog2(FilterCycles+1) bits, saturating.
- Mid-operation reset drops all outputs asynchronously.

Decomposition:
- Shared package pwrmgr_pkg: add typedef wake_arb_state_e (WaIdle, WaArmed, WaReqWake, WaReqRst) and constant WakeFilterW.
- One sub-module pwrmgr_wake_filter (single-source counter + qualify output), instantiated NumWkups times via generate.

Test Plan:
- Filter: lp_entry pulse; wakeup_req_i[2]=1, en=1, filt_en=1 held 3 cycles -> wakeup_o=1 in cycle 4, wake_src_o=2, wake_info_o=4'b0100; 2-cycle glitch -> no wakeup.
- Priority: armed; wakeup[1] and rst_req[0] asserted same cycle -> reset_req_o=1, rst_src_o=0, wakeup_o stays 0, wake_info_o=0.
- Handshake: in WaReqWake, flip pwrup_cause_toggle_i -> wakeup_o=0 next cycle, state WaIdle; a second flip in WaIdle -> no effect.
- Enables/index: wakeup_en_i=4'b1000, wakeup_req_i=4'b1111 unfiltered -> wake_src_o=3, wake_info_o=4'b1000.
- Clear race: clr_info_i same cycle as capture -> wake_info_o shows the new capture; clr_info_i alone later -> wake_info_o=0, src_valid_o=0.
- Reset mid-request: rst_ni low while wakeup_o=1 -> wakeup_o=0 immediately; after release, no request until lp_entry_i.
